// File: rtl/sdram_responder.sv
// Device-side SDR SDRAM responder: decodes the command bus, tracks init/mode/open rows, backs
// accesses with an on-chip RAM. Define SDRAM_RESP_PROTOCOL_CHECK_EN to enable protocol error checks.
module sdram_responder #(
    parameter int unsigned ROW_WIDTH      = 13,
    parameter int unsigned COL_WIDTH      = 9,
    parameter int unsigned BANK_WIDTH     = 2,
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned TRCD           = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clock_enable,
    input  logic                          cs_n,
    input  logic                          ras_n,
    input  logic                          cas_n,
    input  logic                          we_n,
    input  logic [BANK_WIDTH-1:0]         bank_addr,
    input  logic [ROW_WIDTH-1:0]          addr,
    inout  wire  [15:0]                   data,
    input  logic                          data_mask_low,
    input  logic                          data_mask_high,
    output logic                          init_done,
    output logic [(1<<BANK_WIDTH)-1:0]    bank_open,
    output logic [15:0]                   refresh_cnt,
    output logic                          err,
    output logic [2:0]                    err_code
);

    localparam int NUM_BANKS = 1 << BANK_WIDTH;
    localparam int FULL_W    = BANK_WIDTH + ROW_WIDTH + COL_WIDTH;

    typedef enum logic [2:0] {CmdNop, CmdAct, CmdRead, CmdWrite, CmdPre, CmdRef, CmdMrs} cmd_e;
    typedef enum logic [2:0] {StWPall, StWRef1, StWRef2, StWMrs, StReady} init_state_e;

    cmd_e                    cmd;
    init_state_e             init_q;
    logic [NUM_BANKS-1:0]    open_q;
    logic [ROW_WIDTH-1:0]    row_q [NUM_BANKS];
    logic [7:0]              age_q [NUM_BANKS];
    logic [15:0]             refresh_q;
    logic                    cl3_q;
    logic [1:0]              pipe_vld_q;
    logic [15:0]             pipe_dat_q [2];
    logic                    dq_oe_q;
    logic [15:0]             dq_out_q;
    logic [15:0]             mem [1 << MEM_ADDR_WIDTH];
    logic [FULL_W-1:0]       full_addr;
    logic [MEM_ADDR_WIDTH-1:0] mem_idx;
    logic                    rd_ok;
    logic                    wr_ok;
    logic                    cl_valid;

    always_comb begin
        cmd = CmdNop;
        if (clock_enable && !cs_n) begin
            case ({ras_n, cas_n, we_n})
                3'b011:  cmd = CmdAct;
                3'b101:  cmd = CmdRead;
                3'b100:  cmd = CmdWrite;
                3'b010:  cmd = CmdPre;
                3'b001:  cmd = CmdRef;
                3'b000:  cmd = CmdMrs;
                default: cmd = CmdNop;
            endcase
        end
    end

    always_comb begin
        full_addr = {bank_addr, row_q[bank_addr], addr[COL_WIDTH-1:0]};
        mem_idx   = MEM_ADDR_WIDTH'(full_addr);
        rd_ok     = (cmd == CmdRead) && open_q[bank_addr];
        wr_ok     = (cmd == CmdWrite) && open_q[bank_addr];
        cl_valid  = (addr[6:4] == 3'd2) || (addr[6:4] == 3'd3);
    end

    assign data        = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign init_done   = (init_q == StReady);
    assign bank_open   = open_q;
    assign refresh_cnt = refresh_q;

    // Backing RAM is deliberately left out of reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) begin
            if (!data_mask_low)  mem[mem_idx][7:0]  <= data[7:0];
            if (!data_mask_high) mem[mem_idx][15:8] <= data[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_q     <= StWPall;
            open_q     <= '0;
            refresh_q  <= 16'd0;
            cl3_q      <= 1'b1;
            pipe_vld_q <= 2'b00;
            dq_oe_q    <= 1'b0;
            dq_out_q   <= 16'd0;
        end else begin
            // Read pipe: slot 1 feeds slot 0, slot 0 feeds the DQ driver.
            dq_oe_q       <= pipe_vld_q[0];
            dq_out_q      <= pipe_dat_q[0];
            pipe_vld_q    <= {1'b0, pipe_vld_q[1]};
            pipe_dat_q[0] <= pipe_dat_q[1];
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (age_q[i] != 8'hFF) age_q[i] <= age_q[i] + 8'd1;
            end

            case (cmd)
                CmdAct: begin
                    open_q[bank_addr] <= 1'b1;
                    row_q[bank_addr]  <= addr;
                    age_q[bank_addr]  <= 8'd0;
                end
                CmdRead: begin
                    if (rd_ok) begin
                        if (cl3_q) begin
                            pipe_vld_q[1] <= 1'b1;
                            pipe_dat_q[1] <= mem[mem_idx];
                        end else begin
                            pipe_vld_q[0] <= 1'b1;
                            pipe_dat_q[0] <= mem[mem_idx];
                        end
                        if (addr[10]) open_q[bank_addr] <= 1'b0;
                    end
                end
                CmdWrite: begin
                    if (wr_ok && addr[10]) open_q[bank_addr] <= 1'b0;
                end
                CmdPre: begin
                    if (addr[10]) open_q <= '0;
                    else          open_q[bank_addr] <= 1'b0;
                end
                CmdRef: refresh_q <= refresh_q + 16'd1;
                CmdMrs: cl3_q <= !(cl_valid && addr[6:4] == 3'd2);
                default: ;
            endcase

`ifdef SDRAM_RESP_PROTOCOL_CHECK_EN
            case (init_q)
                StWPall: if (cmd == CmdPre && addr[10]) init_q <= StWRef1;
                StWRef1: if (cmd == CmdRef) init_q <= StWRef2;
                StWRef2: if (cmd == CmdRef) init_q <= StWMrs;
                StWMrs:  if (cmd == CmdMrs) init_q <= StReady;
                default: ;
            endcase
`else
            if (cmd == CmdMrs) init_q <= StReady;
`endif
        end
    end

`ifdef SDRAM_RESP_PROTOCOL_CHECK_EN
    logic [2:0] err_now;
    logic       err_q;
    logic [2:0] err_code_q;

    always_comb begin
        err_now = 3'd0;
        case (init_q)
            StWPall: if (cmd != CmdNop && !(cmd == CmdPre && addr[10])) err_now = 3'd1;
            StWRef1, StWRef2: if (cmd != CmdNop && cmd != CmdRef) err_now = 3'd1;
            StWMrs:  if (cmd != CmdNop && cmd != CmdMrs) err_now = 3'd1;
            default: ;
        endcase
        if (err_now == 3'd0) begin
            if (cmd == CmdAct && open_q[bank_addr]) begin
                err_now = 3'd2;
            end else if ((cmd == CmdRead || cmd == CmdWrite) && !open_q[bank_addr]) begin
                err_now = 3'd3;
            end else if ((cmd == CmdRead || cmd == CmdWrite)
                         && age_q[bank_addr] < 8'(TRCD - 1)) begin
                err_now = 3'd4;
            end else if (cmd == CmdMrs && !cl_valid) begin
                err_now = 3'd5;
            end else if (cmd == CmdWrite && dq_oe_q) begin
                err_now = 3'd6;
            end else if (cmd == CmdRef && |open_q) begin
                err_now = 3'd7;
            end
        end
    end

    // Only the first error is recorded; err stays set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_code_q <= 3'd0;
        end else if (!err_q && err_now != 3'd0) begin
            err_q      <= 1'b1;
            err_code_q <= err_now;
        end
    end

    assign err      = err_q;
    assign err_code = err_code_q;
`else
    assign err      = 1'b0;
    assign err_code = 3'd0;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder; released DQ reads back as 0xFFFF via tri1.
`timescale 1ns/1ps
module tb_sdram_responder;

`ifdef SDRAM_RESP_PROTOCOL_CHECK_EN
    localparam bit Chk = 1'b1;
`else
    localparam bit Chk = 1'b0;
`endif

    localparam logic [2:0] ACT = 3'b011, RD = 3'b101, WR = 3'b100, PRE = 3'b010,
                           REF = 3'b001, MRS = 3'b000, NOP = 3'b111;

    logic        clk = 1'b0;
    logic        rst, cke, cs_n, ras_n, cas_n, we_n;
    logic [1:0]  ba;
    logic [12:0] a;
    logic        dqml, dqmh;
    logic        tb_drv;
    logic [15:0] tb_dq;
    tri1  [15:0] dq;
    logic        init_done;
    logic [3:0]  bank_open;
    logic [15:0] refresh_cnt;
    logic        err;
    logic [2:0]  err_code;

    int checks = 0;
    int errors = 0;

    assign dq = tb_drv ? tb_dq : 16'hzzzz;

    always #5 clk = ~clk;

    sdram_responder dut (
        .clk            (clk),
        .rst            (rst),
        .clock_enable   (cke),
        .cs_n           (cs_n),
        .ras_n          (ras_n),
        .cas_n          (cas_n),
        .we_n           (we_n),
        .bank_addr      (ba),
        .addr           (a),
        .data           (dq),
        .data_mask_low  (dqml),
        .data_mask_high (dqmh),
        .init_done      (init_done),
        .bank_open      (bank_open),
        .refresh_cnt    (refresh_cnt),
        .err            (err),
        .err_code       (err_code)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Applies one command at the falling edge; it is sampled at the following rising edge.
    task automatic issue(input logic [2:0] rcw, input logic [1:0] bank, input logic [12:0] ad,
                         input logic drv, input logic [15:0] wd, input logic mh, input logic ml);
        @(negedge clk);
        cs_n = 1'b0;
        {ras_n, cas_n, we_n} = rcw;
        ba = bank; a = ad;
        tb_drv = drv; tb_dq = wd;
        dqmh = mh; dqml = ml;
        #1;
    endtask

    task automatic nop();
        issue(NOP, 2'd0, 13'd0, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    task automatic cmd(input logic [2:0] rcw, input logic [1:0] bank, input logic [12:0] ad);
        issue(rcw, bank, ad, 1'b0, 16'd0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cke = 1'b1; cs_n = 1'b1; ras_n = 1'b1; cas_n = 1'b1; we_n = 1'b1;
        ba = 2'd0; a = 13'd0; dqml = 1'b0; dqmh = 1'b0; tb_drv = 1'b0; tb_dq = 16'd0;

        // Reset state
        nop(); nop();
        check("rst_init_done", 16'(init_done), 16'd0);
        check("rst_bank_open", 16'(bank_open), 16'd0);
        check("rst_refresh", refresh_cnt, 16'd0);
        check("rst_err", 16'(err), 16'd0);
        check("rst_err_code", 16'(err_code), 16'd0);
        check("rst_dq", dq, 16'hFFFF);
        rst = 1'b0;

        // Init sequence, CL=3
        cmd(PRE, 2'd0, 13'h400);
        cmd(REF, 2'd0, 13'd0);
        cmd(REF, 2'd0, 13'd0);
        nop();
        check("init_refresh2", refresh_cnt, 16'd2);
        check("init_not_done", 16'(init_done), 16'd0);
        cmd(MRS, 2'd0, 13'h030);
        nop();
        check("init_done", 16'(init_done), 16'd1);
        check("init_err", 16'(err), 16'd0);

        // Write with auto-precharge, then read back at CL=3
        cmd(ACT, 2'd1, 13'h0005); nop(); nop();
        issue(WR, 2'd1, 13'h0412, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        nop();
        check("wr_autopre_closed", 16'(bank_open), 16'd0);
        cmd(ACT, 2'd1, 13'h0005); nop(); nop();
        cmd(RD, 2'd1, 13'h0012);
        nop(); check("cl3_e0_z", dq, 16'hFFFF);
        nop(); check("cl3_e1_z", dq, 16'hFFFF);
        nop(); check("cl3_data", dq, 16'hBEEF);
        nop(); check("cl3_after_z", dq, 16'hFFFF);
        check("rd_bank_open", 16'(bank_open), 16'h0002);

        // High byte masked write
        issue(WR, 2'd1, 13'h0012, 1'b1, 16'h1234, 1'b1, 1'b0);
        nop();
        cmd(RD, 2'd1, 13'h0012);
        nop(); nop(); nop();
        check("dqm_high_merge", dq, 16'hBE34);
        nop();

        // CL=2 single read, then back-to-back reads
        cmd(MRS, 2'd0, 13'h020);
        nop();
        cmd(RD, 2'd1, 13'h0012);
        nop(); check("cl2_e0_z", dq, 16'hFFFF);
        nop(); check("cl2_data", dq, 16'hBE34);
        nop(); check("cl2_after_z", dq, 16'hFFFF);
        issue(WR, 2'd1, 13'h0013, 1'b1, 16'h5A5A, 1'b0, 1'b0);
        nop();
        cmd(RD, 2'd1, 13'h0012);
        check("b2b_pre_z", dq, 16'hFFFF);
        cmd(RD, 2'd1, 13'h0013);
        check("b2b_pre_z2", dq, 16'hFFFF);
        nop(); check("b2b_word0", dq, 16'hBE34);
        nop(); check("b2b_word1", dq, 16'h5A5A);
        nop(); check("b2b_after_z", dq, 16'hFFFF);
        check("ready_no_err", 16'(err), 16'd0);

        // Read to a closed bank
        cmd(PRE, 2'd1, 13'h0000);
        nop();
        check("pre_closed", 16'(bank_open), 16'd0);
        cmd(RD, 2'd2, 13'h0000);
        nop();
        check("closed_rd_err", 16'(err), Chk ? 16'd1 : 16'd0);
        check("closed_rd_code", 16'(err_code), Chk ? 16'd3 : 16'd0);
        nop(); check("closed_rd_z1", dq, 16'hFFFF);
        nop(); check("closed_rd_z2", dq, 16'hFFFF);
        cmd(ACT, 2'd0, 13'h0000);
        cmd(ACT, 2'd0, 13'h0000);
        nop();
        check("first_err_held", 16'(err_code), Chk ? 16'd3 : 16'd0);
        check("act_b0_open", 16'(bank_open), 16'h0001);

        // Reset while read data is on DQ
        cmd(ACT, 2'd1, 13'h0005); nop(); nop();
        cmd(RD, 2'd1, 13'h0012);
        cmd(RD, 2'd1, 13'h0013);
        nop();
        check("pre_rst_data", dq, 16'hBE34);
        rst = 1'b1;
        nop();
        check("rst_release_dq", dq, 16'hFFFF);
        nop();
        check("rst2_err", 16'(err), 16'd0);
        check("rst2_bank_open", 16'(bank_open), 16'd0);
        check("rst2_init_done", 16'(init_done), 16'd0);
        check("rst2_dq", dq, 16'hFFFF);
        rst = 1'b0;

        // REF with a bank open
        cmd(PRE, 2'd0, 13'h400);
        cmd(REF, 2'd0, 13'd0);
        cmd(REF, 2'd0, 13'd0);
        cmd(MRS, 2'd0, 13'h030);
        cmd(ACT, 2'd0, 13'h0001);
        nop();
        cmd(REF, 2'd0, 13'd0);
        nop();
        check("ref_open_count", refresh_cnt, 16'd3);
        check("ref_open_err", 16'(err), Chk ? 16'd1 : 16'd0);
        check("ref_open_code", 16'(err_code), Chk ? 16'd7 : 16'd0);
        check("ref_open_banks", 16'(bank_open), 16'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
